// File: rtl/spi_byte_engine.sv
// spi_byte_engine: byte-wide SPI master (mode 0, MSB first) for a DivMMC/ZXMMC
// style port decoder. tx shifts out din; rx returns the previously captured byte
// via dout and starts a read-ahead transfer of 0xFF. One pending slot absorbs a
// strobe that arrives mid-transfer; the newest strobe wins.
module spi_byte_engine #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       tx,
   input  logic       rx,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       busy,
   output logic       spi_clk,
   input  logic       spi_di,
   output logic       spi_do
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [2:0] bit_q, bit_d;
   logic       sclk_q, sclk_d;
   logic [7:0] sout_q, sout_d;
   logic [7:0] sin_q, sin_d;
   logic [7:0] dout_q, dout_d;
   logic       pend_vld_q, pend_vld_d;
   logic [7:0] pend_dat_q, pend_dat_d;
   logic       busy_q, busy_d;

   logic       req_s;
   logic [7:0] req_dat_s;
   logic       start_s;
   logic [7:0] start_dat_s;

   // Decode the incoming strobe: tx beats rx, and a read request sends 0xFF.
   // The pending slot only needs the byte to send, so rx is stored as 0xFF.
   always_comb begin
      req_s     = tx | rx;
      req_dat_s = 8'hFF;
      if (tx) begin
         req_dat_s = din;
      end else begin
         req_dat_s = 8'hFF;
      end
   end

   // Next-state logic: SPI clock generation, shifting, completion and request queueing.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      sclk_d      = sclk_q;
      sout_d      = sout_q;
      sin_d       = sin_q;
      dout_d      = dout_q;
      pend_vld_d  = pend_vld_q;
      pend_dat_d  = pend_dat_q;
      start_s     = 1'b0;
      start_dat_s = 8'hFF;

      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               start_s     = 1'b1;
               start_dat_s = req_dat_s;
            end else begin
               start_s     = 1'b0;
            end
         end
         ST_XFER: begin
            // A strobe during a transfer is parked; a newer one overwrites it.
            if (req_s) begin
               pend_vld_d = 1'b1;
               pend_dat_d = req_dat_s;
            end else begin
               pend_vld_d = pend_vld_q;
            end
            if (div_q == DIV_LAST) begin
               div_d  = 8'd0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  // Rising edge: capture MISO.
                  sin_d = {sin_q[6:0], spi_di};
               end else begin
                  // Falling edge: present the next MOSI bit, backfilling ones
                  // so spi_do idles high once the byte is out.
                  sout_d = {sout_q[6:0], 1'b1};
                  bit_d  = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     dout_d     = sin_q;
                     pend_vld_d = 1'b0;
                     // A strobe in the completing cycle is newer than the slot.
                     if (req_s) begin
                        start_s     = 1'b1;
                        start_dat_s = req_dat_s;
                     end else if (pend_vld_q) begin
                        start_s     = 1'b1;
                        start_dat_s = pend_dat_q;
                     end else begin
                        state_d     = ST_IDLE;
                     end
                  end else begin
                     state_d = ST_XFER;
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Launch a transfer: first MSB is on spi_do from the very next edge.
      if (start_s) begin
         state_d = ST_XFER;
         sout_d  = start_dat_s;
         div_d   = 8'd0;
         bit_d   = 3'd0;
         sclk_d  = 1'b0;
      end else begin
         start_dat_s = start_dat_s;
      end

      busy_d = (state_d == ST_XFER) | pend_vld_d;
   end

   // State register with synchronous active-high reset (aborts any transfer).
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         div_q      <= 8'd0;
         bit_q      <= 3'd0;
         sclk_q     <= 1'b0;
         sout_q     <= 8'hFF;
         sin_q      <= 8'hFF;
         dout_q     <= 8'hFF;
         pend_vld_q <= 1'b0;
         pend_dat_q <= 8'hFF;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sclk_q     <= sclk_d;
         sout_q     <= sout_d;
         sin_q      <= sin_d;
         dout_q     <= dout_d;
         pend_vld_q <= pend_vld_d;
         pend_dat_q <= pend_dat_d;
         busy_q     <= busy_d;
      end
   end

   assign dout    = dout_q;
   assign busy    = busy_q;
   assign spi_clk = sclk_q;
   assign spi_do  = sout_q[7];

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: one CLK_DIV=2 instance driven by a
// mode-0 slave model, one CLK_DIV=1 instance in MOSI->MISO loopback.
module tb_spi_byte_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx2, rx2, spi_di2;
   logic [7:0] din2;
   logic [7:0] dout2;
   logic       busy2, spi_clk2, spi_do2;
   logic       tx1, rx1;
   logic [7:0] din1;
   logic [7:0] dout1;
   logic       busy1, spi_clk1, spi_do1;
   wire        spi_di1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spi_byte_engine #(.CLK_DIV(2)) dut2 (
      .clk_sys(clk), .reset(reset), .tx(tx2), .rx(rx2), .din(din2),
      .dout(dout2), .busy(busy2), .spi_clk(spi_clk2), .spi_di(spi_di2), .spi_do(spi_do2)
   );

   assign spi_di1 = spi_do1;

   spi_byte_engine #(.CLK_DIV(1)) dut1 (
      .clk_sys(clk), .reset(reset), .tx(tx1), .rx(rx1), .din(din1),
      .dout(dout1), .busy(busy1), .spi_clk(spi_clk1), .spi_di(spi_di1), .spi_do(spi_do1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a strobe on dut2, then follow the transfer(s) until busy drops.
   // The slave shifts out 'slave' MSB first, advancing on falling spi_clk.
   // Optional mid-transfer tx strobes at sample mid_at (mid_a) and mid_at+2 (mid_b).
   task automatic xfer(input logic st_tx, input logic st_rx, input logic [7:0] st_din,
                       input logic [15:0] slave, input int mid_at,
                       input logic [7:0] mid_a, input logic [7:0] mid_b,
                       input logic [7:0] hold_dout,
                       output logic [15:0] mosi, output int nbusy, output int first_rise,
                       output int nrise, output int early, output logic clk0, output logic do0);
      logic [15:0] sreg;
      logic        prev;
      sreg    = slave;
      spi_di2 = sreg[15];
      tx2     = st_tx;
      rx2     = st_rx;
      din2    = st_din;
      tick();
      tx2 = 1'b0;
      rx2 = 1'b0;
      clk0 = spi_clk2;
      do0  = spi_do2;
      prev = spi_clk2;
      mosi = 16'h0000;
      nbusy = 0;
      first_rise = -1;
      nrise = 0;
      early = 0;
      for (int i = 0; i < 300 && busy2; i++) begin
         nbusy++;
         if (dout2 !== hold_dout) early++;
         if (spi_clk2 && !prev) begin
            mosi = {mosi[14:0], spi_do2};
            nrise++;
            if (first_rise < 0) first_rise = i;
         end
         if (!spi_clk2 && prev) begin
            sreg    = {sreg[14:0], 1'b1};
            spi_di2 = sreg[15];
         end
         prev = spi_clk2;
         if (i == mid_at) begin
            tx2 = 1'b1;
            din2 = mid_a;
         end else if (i == mid_at + 2) begin
            tx2 = 1'b1;
            din2 = mid_b;
         end else begin
            tx2 = 1'b0;
         end
         tick();
      end
      tx2 = 1'b0;
      chk("busy_timeout", {31'd0, busy2}, 32'd0);
   endtask

   logic [15:0] mosi;
   int          nbusy, frise, nrise, early, nb1;
   logic        clk0, do0;

   initial begin
      reset = 1'b1;
      tx2 = 1'b0; rx2 = 1'b0; din2 = 8'h00; spi_di2 = 1'b1;
      tx1 = 1'b0; rx1 = 1'b0; din1 = 8'h00;
      tick();
      tick();
      chk("rst_dout",  {24'd0, dout2}, 32'h0FF);
      chk("rst_busy",  {31'd0, busy2}, 32'd0);
      chk("rst_sclk",  {31'd0, spi_clk2}, 32'd0);
      chk("rst_sdo",   {31'd0, spi_do2}, 32'd1);
      chk("rst1_dout", {24'd0, dout1}, 32'h0FF);
      reset = 1'b0;
      tick();

      // Write A5, slave returns 3C
      xfer(1'b1, 1'b0, 8'hA5, 16'h3CFF, -10, 8'h00, 8'h00, 8'hFF,
           mosi, nbusy, frise, nrise, early, clk0, do0);
      chk("wr_sclk0",  {31'd0, clk0}, 32'd0);
      chk("wr_msb0",   {31'd0, do0}, 32'd1);
      chk("wr_mosi",   {16'd0, mosi}, 32'h00A5);
      chk("wr_busy",   nbusy, 32'd32);
      chk("wr_rise1",  frise, 32'd2);
      chk("wr_nrise",  nrise, 32'd8);
      chk("wr_early",  early, 32'd0);
      chk("wr_dout",   {24'd0, dout2}, 32'h03C);
      chk("wr_sdo_idle", {31'd0, spi_do2}, 32'd1);
      chk("wr_sclk_idle", {31'd0, spi_clk2}, 32'd0);

      // Read-ahead: rx, slave returns 81; dout holds 3C until completion
      xfer(1'b0, 1'b1, 8'h00, 16'h81FF, -10, 8'h00, 8'h00, 8'h3C,
           mosi, nbusy, frise, nrise, early, clk0, do0);
      chk("rd_mosi",   {16'd0, mosi}, 32'h00FF);
      chk("rd_busy",   nbusy, 32'd32);
      chk("rd_early",  early, 32'd0);
      chk("rd_dout",   {24'd0, dout2}, 32'h081);

      // Queued: tx 11, then 22 and 33 mid-transfer; 33 overwrites 22
      xfer(1'b1, 1'b0, 8'h11, 16'h9966, 3, 8'h22, 8'h33, 8'h81,
           mosi, nbusy, frise, nrise, early, clk0, do0);
      chk("q_mosi",    {16'd0, mosi}, 32'h1133);
      chk("q_busy",    nbusy, 32'd64);
      chk("q_nrise",   nrise, 32'd16);
      chk("q_dout",    {24'd0, dout2}, 32'h066);

      // Simultaneous tx and rx: tx wins
      xfer(1'b1, 1'b1, 8'h5A, 16'hC7FF, -10, 8'h00, 8'h00, 8'h66,
           mosi, nbusy, frise, nrise, early, clk0, do0);
      chk("both_msb0", {31'd0, do0}, 32'd0);
      chk("both_mosi", {16'd0, mosi}, 32'h005A);
      chk("both_dout", {24'd0, dout2}, 32'h0C7);

      // Reset mid-transfer, with a strobe parked in the pending slot
      spi_di2 = 1'b0;
      tx2 = 1'b1; din2 = 8'h00;
      tick();
      tx2 = 1'b0;
      tick();
      tx2 = 1'b1; din2 = 8'h77;
      tick();
      tx2 = 1'b0;
      repeat (5) tick();
      chk("ab_busy_pre", {31'd0, busy2}, 32'd1);
      chk("ab_sdo_pre",  {31'd0, spi_do2}, 32'd0);
      reset = 1'b1;
      tick();
      chk("ab_sclk", {31'd0, spi_clk2}, 32'd0);
      chk("ab_sdo",  {31'd0, spi_do2}, 32'd1);
      chk("ab_busy", {31'd0, busy2}, 32'd0);
      chk("ab_dout", {24'd0, dout2}, 32'h0FF);
      reset = 1'b0;
      repeat (3) tick();
      chk("ab_pend_clr", {31'd0, busy2}, 32'd0);
      xfer(1'b1, 1'b0, 8'h96, 16'h4BFF, -10, 8'h00, 8'h00, 8'hFF,
           mosi, nbusy, frise, nrise, early, clk0, do0);
      chk("ab_mosi", {16'd0, mosi}, 32'h0096);
      chk("ab_nbusy", nbusy, 32'd32);
      chk("ab_dout2", {24'd0, dout2}, 32'h04B);

      // CLK_DIV=1 loopback
      tx1 = 1'b1; din1 = 8'hC3;
      tick();
      tx1 = 1'b0;
      nb1 = 0;
      for (int i = 0; i < 100 && busy1; i++) begin
         nb1++;
         tick();
      end
      chk("lb_busy", nb1, 32'd16);
      chk("lb_dout", {24'd0, dout1}, 32'h0C3);
      chk("lb_sdo",  {31'd0, spi_do1}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
